// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA horizontal/vertical timing generator with a built-in
// test-pattern source (colour bars, checkerboard, solid colour, external feed).
// The counters advance on the pixel strobe `en`; every video output is
// registered one enabled cycle behind hcount/vcount so sync and colour align.
module vga_timing_gen #(
    parameter int unsigned  H_ACTIVE = 640,
    parameter int unsigned  H_FP     = 16,
    parameter int unsigned  H_SYNC   = 96,
    parameter int unsigned  H_BP     = 48,
    parameter int unsigned  V_ACTIVE = 480,
    parameter int unsigned  V_FP     = 10,
    parameter int unsigned  V_SYNC   = 2,
    parameter int unsigned  V_BP     = 33,
    parameter logic         HS_POL   = 1'b0,
    parameter logic         VS_POL   = 1'b0,
    parameter int unsigned  CW       = 1,
    parameter int unsigned  BAR_N    = 8,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] solid_rgb,
    input  logic [3*CW-1:0] ext_rgb,
    output logic [HW-1:0]   hcount,
    output logic [VW-1:0]   vcount,
    output logic            hsync,
    output logic            vsync,
    output logic            active,
    output logic            frame_start,
    output logic [CW-1:0]   red,
    output logic [CW-1:0]   green,
    output logic [CW-1:0]   blue
);

    typedef enum logic [1:0] {
        MODE_BARS    = 2'b00,
        MODE_CHECKER = 2'b01,
        MODE_SOLID   = 2'b10,
        MODE_EXT     = 2'b11
    } mode_e;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam int unsigned   H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned   H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned   V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned   V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned   BW           = H_ACTIVE / BAR_N;
    localparam logic [CW-1:0] ONES         = {CW{1'b1}};

    // Counter state and the latched pattern mode
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    mode_e         mode_q, mode_d;

    // Registered video stage (one enabled cycle behind the counters)
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          frame_start_q, frame_start_d;
    logic [CW-1:0] red_q, red_d;
    logic [CW-1:0] green_q, green_d;
    logic [CW-1:0] blue_q, blue_d;

    // Decode of the current counter position
    int unsigned   h_u, v_u;
    logic          at_origin;
    logic          in_active;
    logic          hs_on, vs_on;
    logic [2:0]    bar_code;
    logic          chk_white;
    logic [CW-1:0] pix_r, pix_g, pix_b;

    // Counter advance: wrap at end of line, and at end of frame
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + VW'(1);
                end
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end
    end

    // Position decode; the pattern mode is only taken at the first pixel of a frame
    always_comb begin
        h_u       = 32'(hcount_q);
        v_u       = 32'(vcount_q);
        at_origin = (hcount_q == '0) && (vcount_q == '0);
        in_active = (h_u < H_ACTIVE) && (v_u < V_ACTIVE);
        hs_on     = (h_u >= H_SYNC_START) && (h_u < H_SYNC_END);
        vs_on     = (v_u >= V_SYNC_START) && (v_u < V_SYNC_END);
        chk_white = hcount_q[5] ^ vcount_q[5];
        // The pixel at (0,0) already belongs to the new frame, so it uses the
        // freshly latched mode rather than the previous frame's.
        mode_d    = (en && at_origin) ? mode_e'(mode) : mode_q;
    end

    // Pattern generator: bar index clamps to the last bar for any remainder columns
    always_comb begin
        bar_code = '0;
        pix_r    = '0;
        pix_g    = '0;
        pix_b    = '0;
        for (int unsigned i = 1; i < BAR_N; i++) begin
            if (h_u >= i * BW) begin
                bar_code = 3'(i);
            end
        end
        if (in_active) begin
            case (mode_d)
                MODE_BARS: begin
                    pix_r = {CW{bar_code[0]}};
                    pix_g = {CW{bar_code[1]}};
                    pix_b = {CW{bar_code[2]}};
                end
                MODE_CHECKER: begin
                    pix_r = chk_white ? ONES : '0;
                    pix_g = chk_white ? ONES : '0;
                    pix_b = chk_white ? ONES : '0;
                end
                MODE_SOLID: begin
                    pix_r = solid_rgb[CW-1:0];
                    pix_g = solid_rgb[2*CW-1:CW];
                    pix_b = solid_rgb[3*CW-1:2*CW];
                end
                default: begin
                    pix_r = ext_rgb[CW-1:0];
                    pix_g = ext_rgb[2*CW-1:CW];
                    pix_b = ext_rgb[3*CW-1:2*CW];
                end
            endcase
        end
    end

    // Output stage next values: advance on en, hold otherwise; frame_start never holds
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        frame_start_d = 1'b0;
        if (en) begin
            hsync_d       = hs_on ? HS_POL : ~HS_POL;
            vsync_d       = vs_on ? VS_POL : ~VS_POL;
            active_d      = in_active;
            red_d         = pix_r;
            green_d       = pix_g;
            blue_d        = pix_b;
            frame_start_d = at_origin;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            mode_q        <= MODE_BARS;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            mode_q        <= mode_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule
